// File: rtl/pipe_pkg.sv
// Shared encodings for the EX/WB pipeline controller: instruction field
// positions, opcode classes, ALU function codes, branch sub-ops and the
// decoded-instruction record.
package pipe_pkg;

  localparam int IR_W = 16;
  localparam int RA_W = 3;

  // Instruction field bit positions.
  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 11;
  localparam int RS_HI  = 10;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 5;
  localparam int FN_HI  = 4;
  localparam int FN_LO  = 0;

  // Opcode class in ir[15:14].
  typedef enum logic [1:0] {
    CLS_R    = 2'b00,
    CLS_LI   = 2'b01,
    CLS_BR   = 2'b10,
    CLS_ADDI = 2'b11
  } op_cls_e;

  // R-type function codes the ALU implements.
  localparam logic [4:0] FN_ADD = 5'b00010;
  localparam logic [4:0] FN_CMP = 5'b00100;
  localparam logic [4:0] FN_MLT = 5'b00101;

  // Branch sub-op carried in the rd field of a class-10 instruction.
  localparam logic [RA_W-1:0] BR_OP_B   = 3'b000;
  localparam logic [RA_W-1:0] BR_OP_BNZ = 3'b001;
  localparam logic [RA_W-1:0] BR_OP_BZ  = 3'b010;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_ALWAYS,
    BR_NZ,
    BR_Z
  } br_kind_e;

  // Bubble encoding: matches no ALU case, so the ALU result register holds.
  localparam logic [IR_W-1:0] NOP_ENC = 16'h0000;

  typedef struct packed {
    logic            writes_rd;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            uses_rs;
    logic            uses_rt;
    logic            is_branch;
    br_kind_e        br_kind;
  } dec_t;

  // Branch outcome given the kind and the operand-1 value seen in EX.
  function automatic logic br_taken(input br_kind_e kind,
                                    input logic [IR_W-1:0] sr1);
    logic taken;
    case (kind)
      BR_ALWAYS: taken = 1'b1;
      BR_NZ:     taken = (sr1 != '0);
      BR_Z:      taken = (sr1 == '0);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational instruction decoder: register usage and branch kind.
// One copy each for the ID, EX and WB instructions.
module instr_decode
  import pipe_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output dec_t            dec
);

  // Classify the instruction and report which registers it reads/writes.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // a field unassigned, which would otherwise infer a latch.
    dec           = '0;
    dec.rd        = ir[RD_HI:RD_LO];
    dec.rs        = ir[RS_HI:RS_LO];
    dec.rt        = ir[RT_HI:RT_LO];
    dec.br_kind   = BR_NONE;
    case (op_cls_e'(ir[CLS_HI:CLS_LO]))
      CLS_ADDI: begin
        dec.writes_rd = 1'b1;
        dec.uses_rs   = 1'b1;
      end
      CLS_R: begin
        if (ir[FN_HI:FN_LO] == FN_ADD || ir[FN_HI:FN_LO] == FN_CMP ||
            ir[FN_HI:FN_LO] == FN_MLT) begin
          dec.writes_rd = 1'b1;
          dec.uses_rs   = 1'b1;
          dec.uses_rt   = 1'b1;
        end
      end
      CLS_LI: begin
        // LI needs the rs field to be zero; anything else is a NOP.
        if (ir[RS_HI:RS_LO] == '0) dec.writes_rd = 1'b1;
      end
      CLS_BR: begin
        case (ir[RD_HI:RD_LO])
          BR_OP_B: begin
            if (ir[RS_HI:RS_LO] == '0) dec.br_kind = BR_ALWAYS;
          end
          BR_OP_BNZ: begin
            dec.br_kind = BR_NZ;
            dec.uses_rs = 1'b1;
          end
          BR_OP_BZ: begin
            dec.br_kind = BR_Z;
            dec.uses_rs = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    dec.is_branch = (dec.br_kind != BR_NONE);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// EX/WB sequencing controller: issues ID instructions to the ALU, stalls on
// RAW hazards, selects forwarding, resolves branches in WB and drives
// register-file writeback plus a retired-instruction counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int              CNT_W  = 16,
  parameter logic [IR_W-1:0] NOP_IR = NOP_ENC
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [IR_W-1:0]  id_ir,
  input  logic             id_valid,
  input  logic [IR_W-1:0]  ex_sr1,
  output logic [IR_W-1:0]  ex_ir,
  output logic             pc_en,
  output logic             id_en,
  output logic             id_flush,
  output logic             fwd_sr1,
  output logic             fwd_sr2,
  output logic             wb_we,
  output logic [RA_W-1:0]  wb_addr,
  output logic             pc_load,
  output logic [CNT_W-1:0] retired
);

  logic            ex_valid;
  logic [IR_W-1:0] wb_ir;
  logic            wb_valid;
  logic            wb_taken;

  dec_t id_dec;
  dec_t ex_dec;
  dec_t wb_dec;

  logic raw_hit;
  logic flush;
  logic stall;
  logic issue;
  logic ex_live;
  logic ex_taken;

  instr_decode u_id_dec (.ir(id_ir), .dec(id_dec));
  instr_decode u_ex_dec (.ir(ex_ir), .dec(ex_dec));
  instr_decode u_wb_dec (.ir(wb_ir), .dec(wb_dec));

  // Hazard, flush and branch-resolution decisions for this cycle.
  always_comb begin
    // The EX result is only in the ALU register at the end of EX, so a
    // dependent ID instruction must wait one cycle.
    raw_hit  = id_valid && ex_valid && ex_dec.writes_rd &&
               ((id_dec.uses_rs && (id_dec.rs == ex_dec.rd)) ||
                (id_dec.uses_rt && (id_dec.rt == ex_dec.rd)));
    // A taken branch in WB kills the wrong-path instructions in EX and ID,
    // so it wins over any stall.
    flush    = wb_taken;
    stall    = raw_hit && !flush;
    issue    = !stall && !flush;
    ex_live  = ex_valid && !flush;
    ex_taken = ex_dec.is_branch && br_taken(ex_dec.br_kind, ex_sr1);
  end

  // Control, forwarding and writeback outputs.
  always_comb begin
    pc_en    = !stall;
    id_en    = !stall;
    id_flush = flush;
    pc_load  = flush;
    fwd_sr1  = !flush && wb_valid && wb_dec.writes_rd && (wb_dec.rd == id_dec.rs);
    fwd_sr2  = !flush && wb_valid && wb_dec.writes_rd && (wb_dec.rd == id_dec.rt);
    wb_we    = wb_valid && wb_dec.writes_rd;
    wb_addr  = wb_valid ? wb_dec.rd : '0;
  end

  // EX and WB slot registers and the retired counter.
  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, matching the hardware's simultaneous update.
    if (!RSTN) begin
      ex_ir    <= NOP_IR;
      ex_valid <= 1'b0;
      wb_ir    <= NOP_IR;
      wb_valid <= 1'b0;
      wb_taken <= 1'b0;
      retired  <= '0;
    end else begin
      if (issue) begin
        ex_ir    <= id_ir;
        ex_valid <= id_valid;
      end else begin
        ex_ir    <= NOP_IR;
        ex_valid <= 1'b0;
      end
      wb_ir    <= ex_ir;
      wb_valid <= ex_live;
      wb_taken <= ex_live && ex_taken;
      if (wb_valid) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Sequencing controller for the EX/WB half of the 4-stage CPU pipeline (IF, ID, EX, WB) built around the registered ALU.
- Issues the ID instruction to the ALU, or a bubble.
- Detects RAW hazards and selects operand forwarding.
- Resolves branches from the ALU result cycle and flushes wrong-path instructions.
- Drives register-file writeback and keeps a retired-instruction count.

Parameters:
CNT_W, 16, width of the retired-instruction counter.
NOP_IR, 16'h0000, bubble encoding driven to the ALU; it matches no ALU case, so q holds.

Ports:
CLK  input  1  clock
RSTN  input  1  synchronous active-low reset
id_ir  input  16  instruction currently in the ID register
id_valid  input  1  id_ir holds a real instruction
ex_sr1  input  16  ALU operand 1 value during EX, used for branch condition
ex_ir  output  16  instruction presented to the ALU (ir input)
pc_en  output  1  PC/IF may advance
id_en  output  1  ID register may load
id_flush  output  1  ID register loads invalid
fwd_sr1  output  1  0 = regfile, 1 = ALU q, for operand 1 latched at end of ID
fwd_sr2  output  1  same, for operand 2
wb_we  output  1  register-file write enable
wb_addr  output  3  register-file write address
pc_load  output  1  PC loads ALU q (taken branch)
retired  output  CNT_W  count of instructions completing WB

Behaviour:
Decode fields (fixed):
- rd = ir[13:11], rs = ir[10:8], rt = ir[7:5], func = ir[4:0].
- ADDi 11_xxx: writes rd; reads rs.
- R-type 00, func 00010/00100/00101 (ADD/CMP/MLT): writes rd; reads rs and rt.
- LI 01_xxx_000: writes rd; reads nothing.
- B 10_000_000: always taken.
- BNZ 10_001: reads rs; taken when ex_sr1 != 0.
- BZ 10_010: reads rs; taken when ex_sr1 == 0.
- Any other encoding: NOP; no read, no write, counts as retired if valid.

State:
- EX slot: ex_ir, ex_valid.
- WB slot: wb_ir, wb_valid, wb_taken.
- retired counter.

Reset (RSTN low at posedge):
- ex_ir = NOP_IR; ex_valid = wb_valid = wb_taken = 0; retired = 0.
- Combinational outputs follow from this: pc_en = id_en = 1; id_flush = pc_load = wb_we = 0; fwd = 0; wb_addr = 0.
- Reset mid-operation discards all in-flight instructions.

Stall:
- Condition: id_valid, ex_valid, EX instruction writes rd, and the ID instruction reads that register.
- ALU q is not ready until the end of EX, so the pipeline stalls one cycle.
- During a stall: pc_en = id_en = 0; next EX slot = bubble.

Forwarding:
- fwd_srN = 1 when wb_valid, the WB instruction writes, and wb rd equals the ID source N.
- Otherwise fwd_srN = 0; the regfile write at the edge makes older results visible.

Issue:
- When not stalled and not flushed: ex_ir <= id_ir, ex_valid <= id_valid.
- Otherwise: ex_ir <= NOP_IR, ex_valid <= 0.

EX to WB (every cycle):
- wb_ir <= ex_ir; wb_valid <= ex_valid.
- wb_taken <= ex_valid and the branch is taken per ex_sr1.

Writeback (WB cycle):
- wb_we = wb_valid and the instruction writes; wb_addr = wb rd (0 when invalid).
- retired increments when wb_valid; it wraps modulo 2^CNT_W.

Branch:
- When wb_taken: pc_load = 1 and id_flush = 1.
- EX slot is forced to a bubble, and the current EX instruction has its wb_valid forced to 0 next cycle (ex_valid squashed).
- Taken-branch penalty: 2 bubbles. Not-taken: no penalty.

Simultaneous events:
- Flush overrides stall: pc_en = 1, id_en = 1, id_flush = 1, no stall.
- Forwarding is ignored while flushing.

Throughput and latency:
- No hazards: 1 instruction per cycle.
- Issue to writeback: 2 cycles.

Decomposition:
- Package pipe_pkg: opcode class constants, func constants (ADD = 5'b00010, CMP = 5'b00100, MLT = 5'b00101), branch sub-ops (B/BNZ/BZ), field bit positions, NOP_IR.
- Sub-module instr_decode (combinational): ir -> writes_rd, rd, uses_rs, uses_rt, is_branch, br_kind.
  - Instantiated for the ID instruction, the EX instruction and the WB instruction.

Test Plan:
1. Reset → ex_ir = 0000, wb_we = 0, retired = 0, pc_en = 1.
2. Pulse RSTN low while a branch sits in WB → pc_load = 0 next cycle, valids cleared.
3. id_ir = C805 (ADDi r1,r0,5), next cycle id_ir = 1122 (ADD r2,r1,r1) → one cycle pc_en = id_en = 0 with a bubble in EX. The cycle after, fwd_sr1 = fwd_sr2 = 1. wb_we for r1, then r2 two cycles later; retired = 2.
4. Independent stream 5807 (LI r3,7), C805 → no stall; wb_we each cycle with wb_addr = 3 then 1.
5. 8904 (BNZ r1) with ex_sr1 = 5 → pc_load = 1 and id_flush = 1 in its WB cycle. The two younger instructions produce no wb_we, and retired does not count them.
6. 9104 (BZ r1) with ex_sr1 = 5 → pc_load stays 0 and no flush. With ex_sr1 = 0 → pc_load = 1. 80FE (B) → always pc_load = 1.
7. RAW stall coinciding with a taken branch in WB → id_flush = 1, pc_en = 1, no stall asserted.
